// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder.
//   state_t    : feeder control states
//   flush_len  : cycles spent in FLUSH before results are final
//   lane_lsb   : LSB position of a lane inside a packed N*DW bus
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, HOLD} state_t;

  // The last beat needs 2N-1 more hops to reach PE(N-1,N-1), plus the
  // multiplier latency, before it lands in that PE's sum.
  function automatic int flush_len(input int n, input int mul_lat);
    return 2 * n + mul_lat - 1;
  endfunction

  function automatic int lane_lsb(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/skew_delay.sv
// Zero-reset shift register used to skew operands and clear strobes.
//   clk, rst_n : clock, synchronous active-low reset
//   din        : value entering the line this cycle
//   taps       : every stage; taps[k] is din delayed by k+1 cycles
//   dout       : last stage (din delayed by DEPTH cycles)
module skew_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [W-1:0]              din,
  output logic [DEPTH-1:0][W-1:0]   taps,
  output logic [W-1:0]              dout
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taps <= '0;
    end else begin
      taps[0] <= din;
      for (int k = 1; k < DEPTH; k++) taps[k] <= taps[k-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Transmit side of the systolic MAC array interface.
// Takes one inner-dimension beat per cycle (A column + B row), skews the
// lanes diagonally onto the array edges and generates enable, per-diagonal
// accumulator clears and a done pulse once every PE sum is final.
//   clk, rst_n        : clock, synchronous active-low reset
//   start, k_len      : begin a tile of k_len beats (IDLE/HOLD only)
//   a_valid/a_data/a_ready : A column stream, slice i -> row i
//   b_valid/b_data/b_ready : B row stream, slice j -> column j
//   left_o, up_o      : skewed operands to the array's left / top edges
//   en_o              : array enable
//   clc_diag          : clear strobe, bit d for PEs with i+j=d
//   busy, done        : FEED/FLUSH indicator, results-valid pulse
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N       = 4,
  parameter int in_DW   = 8,
  parameter int K_MAX   = 64,
  parameter int MUL_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [$clog2(K_MAX+1)-1:0] k_len,
  input  logic                       a_valid,
  input  logic [N*in_DW-1:0]         a_data,
  output logic                       a_ready,
  input  logic                       b_valid,
  input  logic [N*in_DW-1:0]         b_data,
  output logic                       b_ready,
  output logic [N*in_DW-1:0]         left_o,
  output logic [N*in_DW-1:0]         up_o,
  output logic                       en_o,
  output logic [2*N-2:0]             clc_diag,
  output logic                       busy,
  output logic                       done
);

  localparam int KW    = $clog2(K_MAX+1);
  localparam int CW    = $clog2(K_MAX);
  localparam int FL    = flush_len(N, MUL_LAT);
  localparam int FW    = $clog2(FL+1);
  localparam int CLC_D = 2*N - 1 + MUL_LAT;

  state_t        state, state_nxt;
  logic [CW-1:0] beat_cnt;
  logic [KW-1:0] k_reg;
  logic [FW-1:0] flush_cnt;
  logic          done_q;

  logic fire, last_beat, start_ok, flush_last, first_beat;

  // A and B are only taken together so the two streams never slip.
  assign fire       = (state == FEED) & a_valid & b_valid;
  assign last_beat  = fire & (KW'(beat_cnt) == k_reg - KW'(1));
  assign start_ok   = start & (k_len != '0) & ((state == IDLE) | (state == HOLD));
  assign flush_last = (flush_cnt == FW'(FL-1));
  assign first_beat = fire & (beat_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      k_reg     <= '0;
      flush_cnt <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == FLUSH) & flush_last;
      if (start_ok) begin
        k_reg    <= k_len;
        beat_cnt <= '0;
      end else if (fire && !last_beat) begin
        // Held at k_len-1 after the last beat so it never wraps.
        beat_cnt <= beat_cnt + CW'(1);
      end
      flush_cnt <= (state == FLUSH && !flush_last) ? flush_cnt + FW'(1) : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    en_o      = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = FEED;
      end
      FEED: begin
        en_o    = 1'b1;
        busy    = 1'b1;
        a_ready = fire;
        b_ready = fire;
        if (last_beat) state_nxt = FLUSH;
      end
      FLUSH: begin
        en_o = 1'b1;
        busy = 1'b1;
        if (flush_last) state_nxt = HOLD;
      end
      HOLD: begin
        // Zeros keep flowing so the PE sums stay put until the next tile.
        en_o = 1'b1;
        if (start_ok) state_nxt = FEED;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign done = done_q;

  // Row i / column j lane gets 1+i / 1+j stages; unaccepted cycles inject 0.
  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int LSB = lane_lsb(i, in_DW);
    logic [in_DW-1:0]       a_in, b_in;
    logic [i:0][in_DW-1:0]  unused_a_taps, unused_b_taps;

    assign a_in = fire ? a_data[LSB +: in_DW] : '0;
    assign b_in = fire ? b_data[LSB +: in_DW] : '0;

    skew_delay #(.DEPTH(1+i), .W(in_DW)) u_a (
      .clk (clk), .rst_n (rst_n), .din (a_in),
      .taps (unused_a_taps), .dout (left_o[LSB +: in_DW])
    );
    skew_delay #(.DEPTH(1+i), .W(in_DW)) u_b (
      .clk (clk), .rst_n (rst_n), .din (b_in),
      .taps (unused_b_taps), .dout (up_o[LSB +: in_DW])
    );
  end

  // First-beat pulse travels one line; diagonal d taps it where the k=0
  // product reaches PEs with i+j=d (1+d hops plus multiplier latency).
  logic [CLC_D-1:0][0:0]   clc_taps;
  logic [MUL_LAT-1:0][0:0] unused_clc_lo;
  logic                    unused_clc_dout;

  skew_delay #(.DEPTH(CLC_D), .W(1)) u_clc (
    .clk (clk), .rst_n (rst_n), .din (first_beat),
    .taps (clc_taps), .dout (unused_clc_dout)
  );

  assign clc_diag      = clc_taps[CLC_D-1:MUL_LAT];
  assign unused_clc_lo = clc_taps[MUL_LAT-1:0];

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: a beat-level reference (accepted
// beats by cycle, first/last beat cycles) predicts every output each cycle,
// and a behavioural PE array built on the observed edges is compared with a
// plain matrix product at each done pulse.
module tb_systolic_feeder;

  localparam int N = 4, DW = 8, K_MAX = 64, ML = 1;
  localparam int KW = $clog2(K_MAX+1), NC = 2*N-1, MAXC = 4096;

  logic clk = 1'b0;
  logic rst_n, start, a_valid, b_valid, a_ready, b_ready, en_o, busy, done;
  logic [KW-1:0]     k_len;
  logic [N*DW-1:0]   a_data, b_data, left_o, up_o;
  logic [NC-1:0]     clc_diag;

  systolic_feeder #(.N(N), .in_DW(DW), .K_MAX(K_MAX), .MUL_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .left_o(left_o), .up_o(up_o), .en_o(en_o), .clc_diag(clc_diag),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0, checks = 0, errors = 0;

  // reference history, indexed by cycle
  logic [N*DW-1:0] acc_a[MAXC], acc_b[MAXC], obs_l[MAXC], obs_u[MAXC];
  logic [NC-1:0]   obs_c[MAXC];
  bit              first_h[MAXC];
  int  floor_c = 0, beat_idx = 0, klen_m = 0, done_at = -1, last_acc = -1, last_done = -1;
  bit  feeding = 0, engaged = 0, acc_now = 0, gold_ok = 0;
  int  gold[N][N];
  logic [N*DW-1:0] cur_a[K_MAX], cur_b[K_MAX];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, want);
    end
  endtask

  function automatic logic signed [DW-1:0] lane(input logic [N*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  function automatic logic [N*DW-1:0] ahist(input int t, input bit is_b);
    if (t < 0 || t < floor_c) return '0;
    return is_b ? acc_b[t] : acc_a[t];
  endfunction

  function automatic bit fhist(input int t);
    if (t < 0 || t < floor_c) return 1'b0;
    return first_h[t];
  endfunction

  // Sum held by PE(i,j) at cycle t: operand reaches PE after i+j hops,
  // product appears ML cycles later, a clear strobe restarts the sum.
  function automatic int pe_sum(input int i, input int j, input int t);
    int s = 0;
    for (int u = floor_c; u < t; u++) begin
      int a = 0, b = 0, p;
      if (u-ML-j >= floor_c) a = lane(obs_l[u-ML-j], i);
      if (u-ML-i >= floor_c) b = lane(obs_u[u-ML-i], j);
      p = a * b;
      if (obs_c[u][i+j]) s = p; else s = s + p;
    end
    return s;
  endfunction

  task automatic tick();
    logic [N*DW-1:0] el, eu;
    logic [NC-1:0]   ec;
    bit acc, can_start;
    @(negedge clk);
    if (cyc >= MAXC-2) begin
      errors++;
      $display("FAIL cycle_budget cyc=%0d", cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "cycle budget exhausted");
    end
    obs_l[cyc] = left_o; obs_u[cyc] = up_o; obs_c[cyc] = clc_diag;
    if (done) last_done = cyc;
    acc = 1'b0;
    can_start = 1'b0;
    if (rst_n) begin
      el = '0; eu = '0; ec = '0;
      for (int i = 0; i < N; i++) begin
        el[i*DW +: DW] = lane(ahist(cyc-1-i, 1'b0), i);
        eu[i*DW +: DW] = lane(ahist(cyc-1-i, 1'b1), i);
      end
      for (int d = 0; d < NC; d++) ec[d] = fhist(cyc-1-d-ML);
      acc = feeding && a_valid && b_valid;
      chk("en_o", en_o, engaged);
      chk("busy", busy, feeding || (done_at > cyc));
      chk("done", done, cyc == done_at);
      chk("a_ready", a_ready, acc);
      chk("b_ready", b_ready, acc);
      chk("left_o", left_o, el);
      chk("up_o", up_o, eu);
      chk("clc_diag", clc_diag, ec);
      if (cyc == done_at && gold_ok)
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) chk("pe_result", pe_sum(i, j, cyc), gold[i][j]);
      can_start = !feeding && (done_at <= cyc) && start && (k_len != 0);
    end
    acc_a[cyc]   = acc ? a_data : '0;
    acc_b[cyc]   = acc ? b_data : '0;
    first_h[cyc] = acc && (beat_idx == 0);
    acc_now      = acc;
    if (!rst_n) begin
      feeding = 0; engaged = 0; done_at = -1; floor_c = cyc + 1;
    end else begin
      if (acc) begin
        last_acc = cyc;
        beat_idx++;
        if (beat_idx == klen_m) begin feeding = 0; done_at = cyc + 2*N + ML; end
      end
      if (can_start) begin feeding = 1; engaged = 1; beat_idx = 0; klen_m = k_len; end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // mode 0: always valid, 1: b_valid low on cycles 2,3, 2: random valids,
  // 3: stray start during FEED, 4: reset three cycles into FLUSH.
  task automatic run_tile(input int k, input int mode, input bit reuse,
                          input bit use_const, input int ca, input int cb, output int t0);
    int beat, n, abort_c;
    if (!reuse)
      for (int bt = 0; bt < k; bt++)
        for (int i = 0; i < N; i++) begin
          cur_a[bt][i*DW +: DW] = use_const ? DW'(ca) : DW'($urandom);
          cur_b[bt][i*DW +: DW] = use_const ? DW'(cb) : DW'($urandom);
        end
    start = 1; k_len = KW'(k); a_valid = 0; b_valid = 0;
    t0 = cyc;
    tick();
    start = 0;
    beat = 0; n = 1;
    while (beat < k && n < 400) begin
      a_data = cur_a[beat]; b_data = cur_b[beat];
      a_valid = 1; b_valid = 1;
      if (mode == 1 && (n == 2 || n == 3)) b_valid = 0;
      if (mode == 2) begin
        a_valid = ($urandom_range(0, 3) != 0);
        b_valid = ($urandom_range(0, 3) != 0);
      end
      if (mode == 3 && n == 2) begin start = 1; k_len = KW'(5); end
      tick();
      start = 0;
      if (acc_now) beat++;
      a_valid = 0; b_valid = 0; a_data = $urandom; b_data = $urandom;
      n++;
    end
    chk("feed_beats", beat, k);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        gold[i][j] = 0;
        for (int bt = 0; bt < k; bt++)
          gold[i][j] += int'(lane(cur_a[bt], i)) * int'(lane(cur_b[bt], j));
      end
    gold_ok = 1;
    if (mode == 4) begin
      repeat (3) tick();
      rst_n = 0; abort_c = cyc;
      tick();
      rst_n = 1;
      repeat (20) tick();
      chk("abort_no_done", last_done >= abort_c, 0);
      chk("abort_idle_en", en_o, 0);
      return;
    end
    n = 0;
    while (cyc < done_at && n < 200) begin tick(); n++; end
  endtask

  initial begin
    int t0, t1;
    rst_n = 0; start = 0; k_len = '0; a_valid = 0; b_valid = 0; a_data = '0; b_data = '0;
    tick(); tick();
    rst_n = 1;
    tick(); tick();
    chk("reset_left", left_o, 0);
    chk("reset_clc", clc_diag, 0);

    // start with k_len==0 is ignored in IDLE
    start = 1; k_len = '0; tick(); start = 0;
    repeat (3) tick();
    chk("klen0_idle_busy", busy, 0);

    // basic k=3 tile from IDLE
    run_tile(3, 0, 0, 0, 0, 0, t0);
    tick(); tick();
    chk("t1_done_cycle", last_done - t0, 12);
    chk("t1_row3_k0", lane(obs_l[t0+5], 3), lane(cur_a[0], 3));
    chk("t1_clc0", obs_c[t0+3][0], 1);
    chk("t1_clc6", obs_c[t0+9][6], 1);

    // same tile with two B bubbles
    run_tile(3, 1, 1, 0, 0, 0, t0);
    tick(); tick();
    chk("t2_done_cycle", last_done - t0, 14);

    // single beat, extreme operands
    run_tile(1, 0, 0, 1, 127, -128, t0);
    tick();
    chk("k1_done_lat", last_done - last_acc, 2*N + ML);
    chk("k1_pe33", pe_sum(3, 3, last_done), -16256);
    tick();

    // back-to-back: second start on the HOLD entry cycle
    run_tile(5, 0, 0, 0, 0, 0, t0);
    run_tile(4, 0, 0, 0, 0, 0, t1);
    chk("b2b_start_gap", t1 - t0 > 0, 1);
    tick(); tick();

    // stray start while feeding
    run_tile(6, 3, 0, 0, 0, 0, t0);
    tick();

    // reset in the middle of FLUSH
    run_tile(8, 4, 0, 0, 0, 0, t0);

    // randomized tiles with random valid patterns and gaps
    for (int r = 0; r < 20; r++) begin
      run_tile(int'($urandom_range(1, 12)), 2, 0, 0, 0, 0, t0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
    end
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Transmit side of the systolic MAC array interface.
- Accepts one inner-dimension beat per cycle: an A column (one element per array row) and a B row (one element per array column).
- Skews the elements diagonally onto the array's left and top edges and generates the common enable, the per-diagonal clear-accumulator strobes and a result-valid pulse.
- Sits between the operand buffers and the N x N PE array.

Parameters:
- N, 4, array dimension (rows = columns).
- in_DW, 8, operand width (signed, two's complement).
- K_MAX, 64, maximum inner-dimension length per tile.
- MUL_LAT, 1, PE multiplier latency in cycles (inputs to product).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  begin tile; sampled only in IDLE or HOLD
- k_len  in  $clog2(K_MAX+1)  beats in tile, 1..K_MAX; sampled with start
- a_valid  in  1  A beat valid
- a_data  in  N*in_DW  A column; slice i drives array row i
- a_ready  out  1  A beat accepted when a_valid & a_ready
- b_valid  in  1  B beat valid
- b_data  in  N*in_DW  B row; slice j drives array column j
- b_ready  out  1  B beat accepted when b_valid & b_ready
- left_o  out  N*in_DW  to in_left of PE(i,0)
- up_o  out  N*in_DW  to in_up of PE(0,j)
- en_o  out  1  array enable
- clc_diag  out  2N-1  clear-accumulator strobe; bit d drives PEs with i+j=d
- busy  out  1  state is FEED or FLUSH
- done  out  1  one-cycle pulse: all PE results valid

Behaviour:
- Reset is synchronous, active-low: rst_n sampled on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - All outputs 0.
  - All skew registers and counters 0.
  - Asserting reset mid-tile aborts the tile with no done pulse.
- States:
  - IDLE: en_o=0; start & k_len!=0 -> FEED. start with k_len==0 is ignored.
  - FEED: en_o=1. a_ready = b_ready = a_valid & b_valid. A beat is accepted only when both streams are valid, so A and B never slip. When beat_cnt reaches k_len-1 and that beat is accepted -> FLUSH.
  - FLUSH: en_o=1, ready=0, zeros fed. Runs 2N+MUL_LAT-1 cycles -> HOLD, with done pulsed on the HOLD entry cycle.
  - HOLD: en_o=1, zeros fed, so PE sums stay constant and results remain readable. start (k_len!=0) -> FEED. No other exit; reset returns to IDLE.
- start is ignored in FEED and FLUSH.
- Ready outputs are 0 outside FEED.
- Bubbles: in a FEED cycle with no accepted beat, both edges are injected with zero. The zero product leaves the sums unchanged.
- Skew:
  - Accepted A element for row i appears on left_o slice i exactly 1+i cycles after acceptance.
  - B element for column j appears on up_o slice j after 1+j cycles.
  - Non-accepted cycles propagate zeros through the same delay line.
- Clear strobe: with the first beat accepted at cycle c0, clc_diag[d] = 1 for exactly one cycle, at c0+1+d+MUL_LAT. This coincides with the k=0 product at PE(i,j), i+j=d. It is 0 in all other cycles, including during bubbles before c0.
- done: with the last beat accepted at cycle cL, done = 1 at cycle cL+2N+MUL_LAT. This is the first cycle in which the PE(N-1,N-1) sum includes beat k_len-1.
- Start from HOLD: the new tile's first products clear through clc_diag; no gap cycle is required.
- Arithmetic: pure data movement, no width change. beat_cnt is $clog2(K_MAX) bits and never wraps, because k_len is at most K_MAX.

Decomposition:
- Shared package systolic_pkg holds:
  - the state enum {IDLE, FEED, FLUSH, HOLD};
  - the FLUSH_LEN = 2N+MUL_LAT-1 function;
  - a lane-slice helper for the packed N*in_DW buses.
- One sub-module, skew_delay:
  - parameterized depth and width;
  - zero-reset shift register;
  - instantiated 2N times, with depth 1+i for row i and 1+j for column j.
  - clc_diag uses one 1-bit skew_delay of depth 2N-1+MUL_LAT, tapped per diagonal.

Test Plan:
- N=4, MUL_LAT=1, k_len=3, both streams always valid, start at cycle 0:
  - beats accepted at cycles 1,2,3;
  - row 3 A element k=0 on left_o at cycle 5;
  - clc_diag[0] at cycle 3, clc_diag[6] at cycle 9;
  - done at cycle 12;
  - the array computes the correct 4x4 product vs the golden model.
- Same tile with b_valid low on cycles 2 and 3:
  - no acceptance in those cycles, zeros injected;
  - done shifts by 2 to cycle 14;
  - results are identical.
- k_len=1 with A all 127 and B all -128: single beat, every PE result equals the quantized -16256; done at cL+9.
- Back-to-back: start asserted on the HOLD entry cycle:
  - second tile accepted;
  - clc_diag clears the old sums;
  - results reflect only the second tile.
- Reset asserted during FLUSH: next cycle state=IDLE, en_o=0, all outputs 0, no done pulse.
- start with k_len=0 in IDLE, and start during FEED: both ignored; the state and beat count are unchanged.
